// File: rtl/line_point_counter.sv
// Walks a table of (x, y) word pairs in an external ROM and counts the pairs
// lying on the line SLOPE*x + y == TARGET (mod 2^W), publishing the count with a done strobe.
module line_point_counter #(
  parameter int unsigned W      = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned SLOPE  = 3,
  parameter int unsigned TARGET = 2,
  parameter int unsigned CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] points
);

  localparam logic [W-1:0]  SlopeW  = W'(SLOPE);
  localparam logic [W-1:0]  TargetW = W'(TARGET);
  localparam logic [CW-1:0] CntMax  = '1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StLoadY,
    StCalc,
    StWaitRel
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] points_q, points_d;

  logic [W-1:0]  v;
  logic          hit;

  // W-bit context: the product and sum wrap exactly modulo 2^W.
  always_comb begin
    v   = SlopeW * x_q + y_q;
    hit = (v == TargetW);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    points_d = points_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          cnt_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = StLoadX;
        end
      end
      StLoadX: begin
        x_d     = mem_rdata;
        addr_d  = addr_q + 1'b1;
        state_d = StLoadY;
      end
      StLoadY: begin
        y_d     = mem_rdata;
        state_d = StCalc;
      end
      StCalc: begin
        if (hit && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (&addr_q) begin
          state_d = StWaitRel;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = StLoadX;
        end
      end
      StWaitRel: begin
        if (!start) begin
          points_d = cnt_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          addr_d   = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      points_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      points_q <= points_d;
    end
  end

  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign points   = points_q;

endmodule

// File: doc/line_point_counter.md
# line_point_counter

Parametrised line-membership counter for the ITC99-style benchmark family. It walks a point table in an external read-only memory, where each entry is an (x, y) word pair. For every pair it evaluates SLOPE*x + y modulo 2^W and counts the pairs whose result equals TARGET. It publishes the count with a one-cycle done strobe once the start request is released. This is the generalised successor of the fixed 8-bit, 16-word line counter: width, table depth, line coefficients and count width are parameters, and it adds asynchronous reset, busy/done handshaking and count saturation.

## Interface
- W, 8: data word width (x, y, evaluation result).
- AW, 4: memory address width; the table holds 2^AW words, which is 2^(AW-1) pairs. AW must be at least 1.
- SLOPE, 3: constant x coefficient; must be less than 2^W.
- TARGET, 2: match value; must be less than 2^W.
- CW, 8: point-count width.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request (level).
- mem_addr  out  AW  registered memory read address.
- mem_rdata  in  W  memory data; combinational function of mem_addr, valid in the same cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when points is updated.
- points  out  CW  result of the last completed run, held between runs.

## Operation
- Internal registers:
  - state
  - x, y (W bits each)
  - cnt (CW bits)
- Reset: while rst=1, all registers, outputs and mem_addr are 0 and state is IDLE. Reset in the middle of a run aborts the run; points reads 0 afterwards.
- IDLE:
  - busy=0.
  - When start=1: cnt<=0, mem_addr<=0, busy<=1, go to LOAD_X.
- LOAD_X: x<=mem_rdata; mem_addr<=mem_addr+1; go to LOAD_Y.
- LOAD_Y: y<=mem_rdata; go to CALC.
- CALC:
  - Compute v = (SLOPE*x + y) mod 2^W. Compute the full product and sum, then truncate to W bits.
  - If v==TARGET and cnt is below 2^CW-1, increment cnt; cnt saturates at 2^CW-1.
  - If mem_addr is all ones, go to WAIT_REL; otherwise mem_addr<=mem_addr+1 and go to LOAD_X.
- The CALC compare uses the updated x and y, so a pair's match decision is taken in its own CALC cycle.
- WAIT_REL:
  - If start=1, stay.
  - If start=0: points<=cnt, done<=1 for exactly one cycle, busy<=0, mem_addr<=0, go to IDLE.
- start is ignored in LOAD_X, LOAD_Y and CALC. Only its level matters in IDLE and WAIT_REL.
- points changes only on a done pulse or on reset.

## Timing
- Each pair takes 3 cycles (LOAD_X, LOAD_Y, CALC). A run has P = 2^(AW-1) pairs.
- Edge 0 samples start=1 in IDLE.
- Pair k is read at addresses 2k and 2k+1, on edges 3k+1 and 3k+2. It is evaluated on edge 3k+3.
- State is WAIT_REL after edge 3P.
- If start is already low, edge 3P+1 asserts done and loads points. With defaults (P=8) that is edge 25.
- busy is high from edge 0 to edge 3P+1.
- A new start may be accepted on the edge immediately after the done cycle. There is no dead cycle beyond the IDLE visit.
- All outputs are registered; there are no combinational input-to-output paths.
- rst deassertion is synchronised by the integrating top level; this block only requires rst to be asynchronous.

## Test plan
- All-zero memory, default parameters, 1-cycle start pulse -> v=0 for every pair; done pulses once on edge 25; points=0; busy high from edge 0 to 25.
- Every pair is (x=0, y=2) -> all 8 pairs match; points=8; mem_addr sequences 0..15 and returns to 0 after done.
- Wrap-around: pairs (1,255) and (0x56,0) alternating -> 3+255 and 258 both wrap to 2, so all 8 match and points=8. Replacing one pair with (1,254) gives points=7.
- start held high through the run -> block stays in WAIT_REL with done=0 and points keeping its previous value. Dropping start gives done on the following edge with points=cnt.
- Assert rst at cycle 10 of a run that previously produced points=8 -> points, busy, done and mem_addr go to 0 immediately. A fresh start then completes normally in 25 edges.
- CW=2, all pairs matching -> cnt saturates; points=3, not 0.
